// File: rtl/iob_skid_buf_pkg.sv
// Shared constants for the iob_skid_buf two-entry skid buffer.
package iob_skid_buf_pkg;

   localparam int IOB_SKID_BUF_STATE_W = 2;

   typedef enum logic [IOB_SKID_BUF_STATE_W-1:0] {
      IOB_SKID_BUF_EMPTY = 2'd0,
      IOB_SKID_BUF_ONE   = 2'd1,
      IOB_SKID_BUF_FULL  = 2'd2
   } iob_skid_buf_state_t;

endpackage

// File: rtl/iob_reg.sv
// Enabled register with asynchronous reset and synchronous flush.
module iob_reg #(
   parameter int                 DATA_W   = 1,
   parameter logic [DATA_W-1:0]  ARST_VAL = '0,
   parameter logic [DATA_W-1:0]  RST_VAL  = '0
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         data_q <= ARST_VAL;
      end else if (rst) begin
         data_q <= RST_VAL;
      end else if (en) begin
         data_q <= d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/iob_skid_buf.sv
// Two-entry skid buffer with registered in_ready/out_valid.
// Define IOB_SKID_BUF_LEVEL_EN to expose the occupancy on port level.
module iob_skid_buf
   import iob_skid_buf_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
`ifdef IOB_SKID_BUF_LEVEL_EN
   ,
   output logic [1:0]        level
`endif
);

   logic [IOB_SKID_BUF_STATE_W-1:0] state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q;
   logic main_en, skid_en;
   logic in_xfer, out_xfer;

   assign in_ready  = (state_q != IOB_SKID_BUF_FULL);
   assign out_valid = (state_q != IOB_SKID_BUF_EMPTY);
   assign out_data  = main_q;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

`ifdef IOB_SKID_BUF_LEVEL_EN
   assign level = state_q;
`endif

   always_comb begin
      state_d = state_q;
      main_d  = in_data;
      main_en = 1'b0;
      skid_en = 1'b0;
      case (state_q)
         IOB_SKID_BUF_EMPTY: begin
            if (in_xfer) begin
               state_d = IOB_SKID_BUF_ONE;
               main_en = 1'b1;
            end
         end
         IOB_SKID_BUF_ONE: begin
            if (in_xfer && out_xfer) begin
               main_en = 1'b1;
            end else if (in_xfer) begin
               state_d = IOB_SKID_BUF_FULL;
               skid_en = 1'b1;
            end else if (out_xfer) begin
               state_d = IOB_SKID_BUF_EMPTY;
            end
         end
         IOB_SKID_BUF_FULL: begin
            if (out_xfer) begin
               state_d = IOB_SKID_BUF_ONE;
               main_d  = skid_q;
               main_en = 1'b1;
            end
         end
         // Encoding 3 cannot be reached; recover to EMPTY.
         default: state_d = IOB_SKID_BUF_EMPTY;
      endcase
   end

   iob_reg #(
      .DATA_W  (IOB_SKID_BUF_STATE_W),
      .ARST_VAL(IOB_SKID_BUF_EMPTY),
      .RST_VAL (IOB_SKID_BUF_EMPTY)
   ) u_state_reg (
      .clk (clk),
      .arst(arst),
      .rst (rst),
      .en  (1'b1),
      .d   (state_d),
      .q   (state_q)
   );

   iob_reg #(
      .DATA_W  (DATA_W),
      .ARST_VAL('0),
      .RST_VAL ('0)
   ) u_main_reg (
      .clk (clk),
      .arst(arst),
      .rst (rst),
      .en  (main_en),
      .d   (main_d),
      .q   (main_q)
   );

   iob_reg #(
      .DATA_W  (DATA_W),
      .ARST_VAL('0),
      .RST_VAL ('0)
   ) u_skid_reg (
      .clk (clk),
      .arst(arst),
      .rst (rst),
      .en  (skid_en),
      .d   (in_data),
      .q   (skid_q)
   );

endmodule

// File: tb/tb_iob_skid_buf.sv
// Self-checking bench for iob_skid_buf: vector table, corner sequences, random scoreboard.
module tb_iob_skid_buf;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          arst = 1'b1;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
`ifdef IOB_SKID_BUF_LEVEL_EN
   logic [1:0]    level;
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] shown = '0;

   typedef struct {
      logic          iv;
      logic [DW-1:0] d;
      logic          ordy;
      logic          r;
      logic          e_ov;
      logic          e_ir;
      logic [DW-1:0] e_od;
   } vec_t;

   vec_t vecs[10];

   iob_skid_buf #(.DATA_W(DW)) dut (
      .clk      (clk),
      .arst     (arst),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready)
`ifdef IOB_SKID_BUF_LEVEL_EN
      ,
      .level    (level)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic check_model(input string nm);
      check({nm, ".out_valid"}, DW'(out_valid), DW'(mq.size() > 0));
      check({nm, ".in_ready"}, DW'(in_ready), DW'(mq.size() < 2));
      check({nm, ".out_data"}, out_data, shown);
`ifdef IOB_SKID_BUF_LEVEL_EN
      check({nm, ".level"}, DW'(level), DW'(mq.size()));
      check({nm, ".level_max"}, DW'(level > 2'd2), '0);
`endif
   endtask

   task automatic model_reset();
      mq.delete();
      shown = '0;
   endtask

   // One clock: drive inputs, advance the queue model, compare after the edge.
   task automatic cycle(input logic iv, input logic [DW-1:0] d,
                        input logic ordy, input logic r, input string nm);
      bit can_push;
      bit can_pop;
      logic [DW-1:0] tmp;
      can_push = (mq.size() < 2);
      can_pop  = (mq.size() > 0);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      rst       = r;
      @(posedge clk);
      #1;
      if (r) begin
         model_reset();
      end else begin
         if (can_pop && ordy) tmp = mq.pop_front();
         if (can_push && iv) mq.push_back(d);
         if (mq.size() > 0) shown = mq[0];
      end
      check_model(nm);
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5};
      vecs[1] = '{1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5};
      vecs[2] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5};
      vecs[3] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5A5A5A5A};
      vecs[4] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5A5A5A5A};
      vecs[5] = '{1'b1, 32'h00000011, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000011};
      vecs[6] = '{1'b1, 32'h00000022, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000022};
      vecs[7] = '{1'b1, 32'h00000033, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000022};
      vecs[8] = '{1'b1, 32'h00000044, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000};
      vecs[9] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000000};

      // Power-on reset state.
      #12;
      check("reset.out_valid", DW'(out_valid), '0);
      check("reset.in_ready", DW'(in_ready), DW'(1));
      check("reset.out_data", out_data, '0);
      arst = 1'b0;
      model_reset();

      // Vector table: backpressure, drain, simultaneous push/pop, flush.
      foreach (vecs[i]) begin
         cycle(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].r, "vec");
         check($sformatf("vec%0d.out_valid", i), DW'(out_valid), DW'(vecs[i].e_ov));
         check($sformatf("vec%0d.in_ready", i), DW'(in_ready), DW'(vecs[i].e_ir));
         check($sformatf("vec%0d.out_data", i), out_data, vecs[i].e_od);
      end

      // Streaming at full rate.
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, DW'(i), 1'b1, 1'b0, "stream");
         check($sformatf("stream%0d.data", i), out_data, DW'(i));
         check($sformatf("stream%0d.in_ready", i), DW'(in_ready), DW'(1));
      end
      cycle(1'b0, '0, 1'b1, 1'b0, "stream_end");

      // Asynchronous reset while FULL, observed before the next edge.
      cycle(1'b1, 32'h12345678, 1'b0, 1'b0, "fill0");
      cycle(1'b1, 32'h9ABCDEF0, 1'b0, 1'b0, "fill1");
      check("fill.full_in_ready", DW'(in_ready), '0);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #2 arst = 1'b1;
      #1;
      check("arst.out_valid", DW'(out_valid), '0);
      check("arst.in_ready", DW'(in_ready), DW'(1));
      check("arst.out_data", out_data, '0);
      model_reset();
      #1 arst = 1'b0;
      cycle(1'b0, '0, 1'b0, 1'b0, "post_arst");

      // Random traffic against the queue model.
      for (int n = 0; n < 10000; n++) begin
         cycle(1'($urandom_range(0, 3) != 0), $urandom,
               1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 199) == 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
